// File: rtl/otter_lsu_pkg.sv
// Shared types and lane-steering helpers for the OTTER load/store unit.
package otter_lsu_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_REQ,
    ST_RESP
  } lsu_state_t;

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;

  // Word enables are shifted too, so an untrapped misaligned word keeps only the in-word lanes.
  function automatic logic [3:0] lane_be(input logic [1:0] sz, input logic [1:0] a);
    case (sz)
      SZ_BYTE: lane_be = 4'b0001 << a;
      SZ_HALF: lane_be = 4'b0011 << {a[1], 1'b0};
      default: lane_be = 4'b1111 << a;
    endcase
  endfunction

  function automatic logic [31:0] lane_wdata(input logic [1:0] sz, input logic [31:0] wd);
    case (sz)
      SZ_BYTE: lane_wdata = {4{wd[7:0]}};
      SZ_HALF: lane_wdata = {2{wd[15:0]}};
      default: lane_wdata = wd;
    endcase
  endfunction

  function automatic logic [31:0] load_extend(input logic [31:0] rdata, input logic [1:0] sz,
                                              input logic uns, input logic [1:0] a);
    logic [31:0] sh;
    sh = rdata >> {a, 3'b000};
    case (sz)
      SZ_BYTE: load_extend = uns ? {24'h0, sh[7:0]} : {{24{sh[7]}}, sh[7:0]};
      SZ_HALF: load_extend = uns ? {16'h0, sh[15:0]} : {{16{sh[15]}}, sh[15:0]};
      default: load_extend = sh;
    endcase
  endfunction

  function automatic logic is_misaligned(input logic [1:0] sz, input logic [1:0] a);
    is_misaligned = ((sz == SZ_HALF) && a[0]) || (sz[1] && (a != 2'b00));
  endfunction

endpackage

// File: rtl/otter_lsu_align.sv
// Combinational lane steering: byte enables, store replication, load extract/extend.
module otter_lsu_align
  import otter_lsu_pkg::*;
(
  input  logic [1:0]  addr_lo,
  input  logic [2:0]  funct3,
  input  logic [31:0] wdata,
  input  logic [31:0] rdata,
  output logic [3:0]  be,
  output logic [31:0] wdata_rep,
  output logic [31:0] load_val
);

  always_comb begin
    be        = lane_be(funct3[1:0], addr_lo);
    wdata_rep = lane_wdata(funct3[1:0], wdata);
    load_val  = load_extend(rdata, funct3[1:0], funct3[2], addr_lo);
  end

endmodule

// File: rtl/otter_lsu.sv
// OTTER load/store unit: request/ack bus master with timeout abort.
// Optional misaligned-access trap enabled by defining OTTER_LSU_MISALIGN_TRAP_EN.
module otter_lsu
  import otter_lsu_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 16
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        MEM_READ2,
  input  logic        MEM_WRITE,
  input  logic [31:0] ADDR,
  input  logic [2:0]  FUNCT3,
  input  logic [31:0] WDATA,
  output logic        BUSY,
  output logic        DONE,
  output logic [31:0] LOAD_DATA,
  output logic        BUS_ERR,
  output logic        BUS_REQ,
  output logic        BUS_WE,
  output logic [31:0] BUS_ADDR,
  output logic [3:0]  BUS_BE,
  output logic [31:0] BUS_WDATA,
  input  logic [31:0] BUS_RDATA,
  input  logic        BUS_ACK
);

  localparam int unsigned TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TW-1:0] TO_LIMIT = TW'(TIMEOUT_CYCLES);

  lsu_state_t    state;
  logic [1:0]    a_q;
  logic [2:0]    f3_q;
  logic [TW-1:0] tcnt;
  logic [TW-1:0] tcnt_nx;
  logic [1:0]    al_a;
  logic [2:0]    al_f3;
  logic [3:0]    al_be;
  logic [31:0]   al_wdata;
  logic [31:0]   al_load;

  // Live inputs steer the lanes when issuing; latched ones steer the load extract.
  always_comb begin
    al_a    = (state == ST_IDLE) ? ADDR[1:0] : a_q;
    al_f3   = (state == ST_IDLE) ? FUNCT3 : f3_q;
    tcnt_nx = tcnt + TW'(1);
  end

  otter_lsu_align u_align (
    .addr_lo  (al_a),
    .funct3   (al_f3),
    .wdata    (WDATA),
    .rdata    (BUS_RDATA),
    .be       (al_be),
    .wdata_rep(al_wdata),
    .load_val (al_load)
  );

  always_ff @(posedge CLK) begin
    if (RST) begin
      state     <= ST_IDLE;
      a_q       <= '0;
      f3_q      <= '0;
      tcnt      <= '0;
      BUSY      <= 1'b0;
      DONE      <= 1'b0;
      BUS_ERR   <= 1'b0;
      BUS_REQ   <= 1'b0;
      BUS_WE    <= 1'b0;
      BUS_ADDR  <= '0;
      BUS_BE    <= '0;
      BUS_WDATA <= '0;
      LOAD_DATA <= '0;
    end else begin
      DONE    <= 1'b0;
      BUS_ERR <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (MEM_READ2 || MEM_WRITE) begin
            a_q  <= ADDR[1:0];
            f3_q <= FUNCT3;
            tcnt <= '0;
            BUSY <= 1'b1;
`ifdef OTTER_LSU_MISALIGN_TRAP_EN
            if (is_misaligned(FUNCT3[1:0], ADDR[1:0])) begin
              state   <= ST_RESP;
              DONE    <= 1'b1;
              BUS_ERR <= 1'b1;
              BUS_WE  <= MEM_WRITE;
              if (!MEM_WRITE) LOAD_DATA <= '0;
            end else
`endif
            begin
              state     <= ST_REQ;
              BUS_REQ   <= 1'b1;
              BUS_WE    <= MEM_WRITE;
              BUS_ADDR  <= {ADDR[31:2], 2'b00};
              BUS_BE    <= al_be;
              BUS_WDATA <= al_wdata;
            end
          end
        end
        ST_REQ: begin
          if (BUS_ACK) begin
            state   <= ST_RESP;
            BUS_REQ <= 1'b0;
            DONE    <= 1'b1;
            if (!BUS_WE) LOAD_DATA <= al_load;
          end else begin
            tcnt <= tcnt_nx;
            if (tcnt_nx == TO_LIMIT) begin
              state   <= ST_RESP;
              BUS_REQ <= 1'b0;
              BUS_ERR <= 1'b1;
              DONE    <= 1'b1;
              if (!BUS_WE) LOAD_DATA <= '0;
            end
          end
        end
        ST_RESP: begin
          state <= ST_IDLE;
          BUSY  <= 1'b0;
        end
        default: begin
          state <= ST_IDLE;
          BUSY  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_otter_lsu.sv
// Self-checking bench for otter_lsu: vector table, hand sequences, randomized model check.
module tb_otter_lsu;

  localparam int TIMEOUT = 16;

  logic        CLK = 1'b0;
  logic        RST, MEM_READ2, MEM_WRITE, BUS_ACK;
  logic [31:0] ADDR, WDATA, BUS_RDATA;
  logic [2:0]  FUNCT3;
  logic        BUSY, DONE, BUS_ERR, BUS_REQ, BUS_WE;
  logic [31:0] LOAD_DATA, BUS_ADDR, BUS_WDATA;
  logic [3:0]  BUS_BE;

  int errors = 0;
  int checks = 0;
  logic [31:0] ld_hold;

  otter_lsu #(.TIMEOUT_CYCLES(TIMEOUT)) dut (
    .CLK(CLK), .RST(RST), .MEM_READ2(MEM_READ2), .MEM_WRITE(MEM_WRITE),
    .ADDR(ADDR), .FUNCT3(FUNCT3), .WDATA(WDATA), .BUSY(BUSY), .DONE(DONE),
    .LOAD_DATA(LOAD_DATA), .BUS_ERR(BUS_ERR), .BUS_REQ(BUS_REQ), .BUS_WE(BUS_WE),
    .BUS_ADDR(BUS_ADDR), .BUS_BE(BUS_BE), .BUS_WDATA(BUS_WDATA),
    .BUS_RDATA(BUS_RDATA), .BUS_ACK(BUS_ACK)
  );

  always #5 CLK = ~CLK;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got no end of test, required finish within time limit");
    $fatal(1, "watchdog expired");
  end

  typedef struct {
    string       tag;
    logic        wr, rd;
    logic [31:0] addr;
    logic [2:0]  f3;
    logic [31:0] wd, rdat;
    int          waits;
    logic [3:0]  e_be;
    logic [31:0] e_wd, e_ld;
    int          e_lat;
    logic        e_err, e_trap;
  } vec_t;

  vec_t vecs[11];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h required %h", name, act, exp);
    end
  endtask

  // Reference rules, stated arithmetically.
  function automatic logic [3:0] m_be(input logic [2:0] f3, input logic [1:0] a);
    int unsigned sz = f3[1:0];
    int unsigned ai = a;
    if (sz == 0) return 4'((1 << ai) % 16);
    if (sz == 1) return (ai >= 2) ? 4'd12 : 4'd3;
    return 4'((15 << ai) % 16);
  endfunction

  function automatic logic [31:0] m_wdata(input logic [2:0] f3, input logic [31:0] wd);
    if (f3[1:0] == 2'd0) return (wd % 256) * 32'h0101_0101;
    if (f3[1:0] == 2'd1) return (wd % 65536) * 32'h0001_0001;
    return wd;
  endfunction

  function automatic logic [31:0] m_load(input logic [31:0] rd, input logic [2:0] f3, input logic [1:0] a);
    logic [31:0] sh, v;
    sh = rd >> (8 * int'(a));
    if (f3[1:0] == 2'd0) begin
      v = sh % 256;
      if (!f3[2] && v >= 128) v = v - 256;
    end else if (f3[1:0] == 2'd1) begin
      v = sh % 65536;
      if (!f3[2] && v >= 32768) v = v - 65536;
    end else begin
      v = sh;
    end
    return v;
  endfunction

  function automatic bit m_misal(input logic [2:0] f3, input logic [1:0] a);
    return (f3[1:0] == 2'd1 && a % 2 == 1) || (f3[1:0] >= 2'd2 && a != 0);
  endfunction

  task automatic txn(input string tag, input logic wr, input logic rd, input logic [31:0] addr,
                     input logic [2:0] f3, input logic [31:0] wd, input logic [31:0] rdat,
                     input int waits, input logic [3:0] e_be, input logic [31:0] e_wd,
                     input logic [31:0] e_ld, input int e_lat, input logic e_err, input logic e_trap);
    int c, dcyc, reqc, exp_reqc;
    bit stable;
    logic [31:0] e_addr;
    e_addr   = {addr[31:2], 2'b00};
    exp_reqc = e_trap ? 0 : (e_err ? TIMEOUT : waits + 1);
    MEM_WRITE = wr; MEM_READ2 = rd; ADDR = addr; FUNCT3 = f3; WDATA = wd;
    @(negedge CLK);
    MEM_WRITE = 1'b0; MEM_READ2 = 1'b0;
    ADDR = $urandom; FUNCT3 = 3'($urandom); WDATA = $urandom;
    if (!e_trap) begin
      chk({tag, ".be"}, 32'(BUS_BE), 32'(e_be));
      chk({tag, ".addr"}, BUS_ADDR, e_addr);
      chk({tag, ".we"}, 32'(BUS_WE), 32'(wr));
      if (wr) chk({tag, ".wdata"}, BUS_WDATA, e_wd);
    end
    c = 1; dcyc = -1; reqc = 0; stable = 1;
    while (dcyc < 0 && c <= 40) begin
      if (DONE === 1'b1) dcyc = c;
      else begin
        if (BUS_REQ === 1'b1) reqc++;
        if (BUSY !== 1'b1 || BUS_ERR !== 1'b0) stable = 0;
        if (!e_trap && (BUS_BE !== e_be || BUS_ADDR !== e_addr || (wr && BUS_WDATA !== e_wd))) stable = 0;
        if (!e_err && c - 1 == waits) begin BUS_ACK = 1'b1; BUS_RDATA = rdat; end
        @(negedge CLK);
        BUS_ACK = 1'b0; BUS_RDATA = $urandom;
        c++;
      end
    end
    chk({tag, ".done_lat"}, 32'(dcyc), 32'(e_lat));
    chk({tag, ".req_cycles"}, 32'(reqc), 32'(exp_reqc));
    chk({tag, ".held"}, 32'(stable), 32'd1);
    if (dcyc > 0) begin
      chk({tag, ".err"}, 32'(BUS_ERR), 32'(e_err));
      chk({tag, ".req_low"}, 32'(BUS_REQ), 32'd0);
      chk({tag, ".load"}, LOAD_DATA, e_ld);
      @(negedge CLK);
      chk({tag, ".done_pulse"}, {DONE, BUS_ERR, BUSY}, 32'd0);
    end
  endtask

  task automatic rnd_one(input int i);
    logic wr, rd, trap, tout;
    logic [31:0] addr, wd, rdat, e_ld;
    logic [2:0] f3;
    int sel, waits, lat;
    sel = $urandom_range(0, 2);
    wr = (sel != 0); rd = (sel != 1);
    addr = $urandom; f3 = 3'($urandom); wd = $urandom; rdat = $urandom;
    waits = ($urandom_range(0, 9) == 0) ? 99 : $urandom_range(0, 4);
    trap = 1'b0;
`ifdef OTTER_LSU_MISALIGN_TRAP_EN
    trap = m_misal(f3, addr[1:0]);
`endif
    tout = !trap && waits >= TIMEOUT;
    if (wr) e_ld = ld_hold;
    else if (trap || tout) e_ld = 32'd0;
    else e_ld = m_load(rdat, f3, addr[1:0]);
    ld_hold = e_ld;
    lat = trap ? 1 : (tout ? TIMEOUT + 1 : waits + 2);
    txn($sformatf("rnd%0d", i), wr, rd, addr, f3, wd, rdat, waits,
        m_be(f3, addr[1:0]), m_wdata(f3, wd), e_ld, lat, trap || tout, trap);
  endtask

  initial begin
    vecs[0] = '{"ld_b_s",  1'b0, 1'b1, 32'h1003, 3'b000, 32'h0, 32'h80FF_0000, 0, 4'b1000, 32'h0, 32'hFFFF_FF80, 2, 1'b0, 1'b0};
    vecs[1] = '{"st_h",    1'b1, 1'b0, 32'h2002, 3'b001, 32'h1234_ABCD, 32'h0, 3, 4'b1100, 32'hABCD_ABCD, 32'hFFFF_FF80, 5, 1'b0, 1'b0};
    vecs[2] = '{"ld_h_u",  1'b0, 1'b1, 32'h2002, 3'b101, 32'h0, 32'h8001_7FFF, 1, 4'b1100, 32'h0, 32'h0000_8001, 3, 1'b0, 1'b0};
    vecs[3] = '{"ld_b_u",  1'b0, 1'b1, 32'h0011, 3'b100, 32'h0, 32'h0000_9A00, 0, 4'b0010, 32'h0, 32'h0000_009A, 2, 1'b0, 1'b0};
    vecs[4] = '{"st_w",    1'b1, 1'b0, 32'h0040, 3'b010, 32'hDEAD_BEEF, 32'h0, 0, 4'b1111, 32'hDEAD_BEEF, 32'h0000_009A, 2, 1'b0, 1'b0};
    vecs[5] = '{"st_b",    1'b1, 1'b0, 32'h0042, 3'b000, 32'h0000_00A5, 32'h0, 0, 4'b0100, 32'hA5A5_A5A5, 32'h0000_009A, 2, 1'b0, 1'b0};
    vecs[6] = '{"st_both", 1'b1, 1'b1, 32'h0050, 3'b010, 32'h0102_0304, 32'h0, 2, 4'b1111, 32'h0102_0304, 32'h0000_009A, 4, 1'b0, 1'b0};
    vecs[7] = '{"ld_h_s",  1'b0, 1'b1, 32'h0100, 3'b001, 32'h0, 32'h1234_8765, 0, 4'b0011, 32'h0, 32'hFFFF_8765, 2, 1'b0, 1'b0};
    vecs[8] = '{"ld_w11",  1'b0, 1'b1, 32'h0200, 3'b011, 32'h0, 32'hCAFE_F00D, 0, 4'b1111, 32'h0, 32'hCAFE_F00D, 2, 1'b0, 1'b0};
    vecs[9] = '{"tmo",     1'b0, 1'b1, 32'h0300, 3'b010, 32'h0, 32'h0, 99, 4'b1111, 32'h0, 32'h0, 17, 1'b1, 1'b0};
`ifdef OTTER_LSU_MISALIGN_TRAP_EN
    vecs[10] = '{"misal_w", 1'b0, 1'b1, 32'h3001, 3'b010, 32'h0, 32'hAABB_CCDD, 0, 4'b0000, 32'h0, 32'h0, 1, 1'b1, 1'b1};
`else
    vecs[10] = '{"misal_w", 1'b0, 1'b1, 32'h3001, 3'b010, 32'h0, 32'hAABB_CCDD, 0, 4'b1110, 32'h0, 32'h00AA_BBCC, 2, 1'b0, 1'b0};
`endif

    RST = 1'b1; MEM_READ2 = 1'b0; MEM_WRITE = 1'b0; BUS_ACK = 1'b0;
    ADDR = '0; FUNCT3 = '0; WDATA = '0; BUS_RDATA = '0;
    @(negedge CLK); @(negedge CLK);
    RST = 1'b0;
    chk("rst.ctrl", {BUSY, DONE, BUS_ERR, BUS_REQ, BUS_WE}, 32'd0);
    chk("rst.addr", BUS_ADDR, 32'd0);
    chk("rst.be_wdata", BUS_WDATA | 32'(BUS_BE), 32'd0);
    chk("rst.load", LOAD_DATA, 32'd0);

    foreach (vecs[i])
      txn(vecs[i].tag, vecs[i].wr, vecs[i].rd, vecs[i].addr, vecs[i].f3, vecs[i].wd,
          vecs[i].rdat, vecs[i].waits, vecs[i].e_be, vecs[i].e_wd, vecs[i].e_ld,
          vecs[i].e_lat, vecs[i].e_err, vecs[i].e_trap);
    ld_hold = vecs[10].e_ld;

    // Strobes during REQ and RESP must not start a second access.
    begin
      int extra;
      MEM_READ2 = 1'b1; ADDR = 32'h0060; FUNCT3 = 3'b010;
      @(negedge CLK); MEM_READ2 = 1'b0;
      @(negedge CLK); MEM_WRITE = 1'b1; ADDR = 32'h0070;
      @(negedge CLK); MEM_WRITE = 1'b0; BUS_ACK = 1'b1; BUS_RDATA = 32'h1357_9BDF;
      @(negedge CLK); BUS_ACK = 1'b0; MEM_WRITE = 1'b1;
      chk("busy.done", 32'(DONE), 32'd1);
      chk("busy.addr", BUS_ADDR, 32'h0000_0060);
      chk("busy.we", 32'(BUS_WE), 32'd0);
      chk("busy.load", LOAD_DATA, 32'h1357_9BDF);
      ld_hold = 32'h1357_9BDF;
      @(negedge CLK); MEM_WRITE = 1'b0;
      extra = 0;
      for (int k = 0; k < 3; k++) begin
        if (BUS_REQ !== 1'b0 || BUSY !== 1'b0) extra++;
        @(negedge CLK);
      end
      chk("busy.no_second_req", 32'(extra), 32'd0);
    end

    // Reset in the second REQ cycle abandons the access.
    begin
      int dones;
      MEM_READ2 = 1'b1; ADDR = 32'h0400; FUNCT3 = 3'b010;
      @(negedge CLK); MEM_READ2 = 1'b0;
      chk("mrst.req_before", 32'(BUS_REQ), 32'd1);
      @(negedge CLK); RST = 1'b1;
      @(negedge CLK); RST = 1'b0;
      chk("mrst.req_busy", {BUS_REQ, BUSY, DONE}, 32'd0);
      chk("mrst.load", LOAD_DATA, 32'd0);
      dones = 0;
      for (int k = 0; k < 4; k++) begin
        if (DONE !== 1'b0 || BUS_REQ !== 1'b0) dones++;
        @(negedge CLK);
      end
      chk("mrst.no_done", 32'(dones), 32'd0);
      ld_hold = 32'h0000_00EE;
      txn("mrst.after", 1'b0, 1'b1, 32'h0500, 3'b100, 32'h0, 32'h0000_00EE, 1,
          4'b0001, 32'h0, 32'h0000_00EE, 3, 1'b0, 1'b0);
    end

    for (int i = 0; i < 40; i++) rnd_one(i);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
